// File: rtl/dma_dev_port.sv
// Device-side DMA port: takes core commands, requests the DMA controller and
// moves data through an 8-entry buffer. Define DMA_DEV_TIMEOUT_EN for the stream watchdog.
module dma_dev_port #(
  parameter int ADD_LEN    = 16,
  parameter int DATA_LEN   = 16,
  parameter int FIFO_DEPTH = 5,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rd_wr,
  input  logic [ADD_LEN-1:0]    cmd_addr,
  input  logic [FIFO_DEPTH-1:0] cmd_len,
  input  logic [DATA_LEN-1:0]   wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_LEN-1:0]   rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rqst,
  output logic                  rd_wr,
  output logic [ADD_LEN-1:0]    start_addr,
  output logic [FIFO_DEPTH-1:0] num_words,
  output logic                  dev_ack,
  output logic [DATA_LEN-1:0]   dev_in,
  input  logic                  dma_ack,
  input  logic [DATA_LEN-1:0]   dev_out,
  input  logic                  end_flag
);
  // state     | meaning
  // IDLE      | waiting for a command, cmd_ready high
  // REQ0/REQ1 | two-cycle request to the DMA controller
  // WR_STREAM | buffered core data handed to the controller
  // RD_STREAM | controller data buffered for the core
  // DRAIN     | read ended, emptying buffer to the core
  // DONE      | one-cycle completion pulse
  // TOUT      | watchdog expired, buffer flushed (optional)
  typedef enum logic [2:0] {
    IDLE, REQ0, REQ1, WR_STREAM, RD_STREAM, DRAIN, DONE
`ifdef DMA_DEV_TIMEOUT_EN
    , TOUT
`endif
  } state_t;

  localparam int ENTRIES = 1 << BUF_DEPTH;
  localparam logic [BUF_DEPTH:0] FULL_CNT = (BUF_DEPTH+1)'(ENTRIES);
  localparam logic [BUF_DEPTH:0] ACK_MAX  = (BUF_DEPTH+1)'(ENTRIES - 2);

  state_t                state;
  logic [ADD_LEN-1:0]    addr_q;
  logic [FIFO_DEPTH-1:0] len_q, push_cnt;
  logic                  rd_wr_q;
  logic [DATA_LEN-1:0]   mem [ENTRIES];
  logic [BUF_DEPTH-1:0]  wr_ptr, rd_ptr;
  logic [BUF_DEPTH:0]    count;
  logic                  full, empty, accept, flush;
  logic                  push_wr, push_rd, pop_wr, pop_rd, do_push, do_pop;
  logic [DATA_LEN-1:0]   head, push_data;
`ifdef DMA_DEV_TIMEOUT_EN
  logic [9:0]            wd;
`endif

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rqst       = (state == REQ0) || (state == REQ1);
  assign rd_wr      = busy && rd_wr_q;
  assign start_addr = busy ? addr_q : '0;
  assign num_words  = busy ? len_q : '0;

  assign wr_ready = !full && !rd_wr_q && (push_cnt < len_q) &&
                    ((state == REQ0) || (state == REQ1) || (state == WR_STREAM));
  assign dev_ack  = ((state == WR_STREAM) && !empty) ||
                    ((state == RD_STREAM) && (count <= ACK_MAX));
  assign dev_in   = (!empty && !rd_wr_q) ? head : '0;
  assign rd_valid = !empty && rd_wr_q && ((state == RD_STREAM) || (state == DRAIN));
  assign rd_data  = rd_valid ? head : '0;

  assign accept    = cmd_valid && (state == IDLE);
  assign push_wr   = wr_valid && wr_ready;
  assign push_rd   = dma_ack && dev_ack && (state == RD_STREAM);
  assign pop_wr    = dma_ack && dev_ack && (state == WR_STREAM);
  assign pop_rd    = rd_valid && rd_ready;
  assign push_data = push_rd ? dev_out : wr_data;
  assign do_push   = (push_wr || push_rd) && !full;
  assign do_pop    = (pop_wr || pop_rd) && !empty;
`ifdef DMA_DEV_TIMEOUT_EN
  assign flush = accept || (state == TOUT);
`else
  assign flush = accept;
`endif

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at BUF_DEPTH bits; stale data is discarded on each accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      rd_wr_q  <= 1'b0;
      push_cnt <= '0;
      err      <= 1'b0;
`ifdef DMA_DEV_TIMEOUT_EN
      wd       <= '0;
`endif
    end else begin
      if (dma_ack && !dev_ack) err <= 1'b1;
      if (push_wr) push_cnt <= push_cnt + 1'b1;
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q   <= cmd_addr;
          len_q    <= cmd_len;
          rd_wr_q  <= cmd_rd_wr;
          push_cnt <= '0;
          err      <= (cmd_len == '0) || dma_ack;
          state    <= (cmd_len == '0) ? DONE : REQ0;
        end
        REQ0: state <= REQ1;
        REQ1: begin
          state <= rd_wr_q ? RD_STREAM : WR_STREAM;
`ifdef DMA_DEV_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WR_STREAM, RD_STREAM: begin
          if (end_flag) state <= (state == WR_STREAM) ? DONE : DRAIN;
`ifdef DMA_DEV_TIMEOUT_EN
          else if (dma_ack) wd <= '0;
          else if (wd == '1) begin
            state <= TOUT;
            err   <= 1'b1;
          end else wd <= wd + 1'b1;
`endif
        end
        DRAIN: if (empty) state <= DONE;
        DONE:  state <= IDLE;
`ifdef DMA_DEV_TIMEOUT_EN
        TOUT:  state <= DONE;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_dev_port.sv
// Directed scoreboard bench for dma_dev_port: write, read backpressure, wrap,
// error cases and mid-transfer reset; watchdog case when DMA_DEV_TIMEOUT_EN is defined.
module tb_dma_dev_port;
  logic        clk = 0, reset = 1;
  logic        cmd_valid = 0, cmd_ready, cmd_rd_wr = 0;
  logic [15:0] cmd_addr = 0;
  logic [4:0]  cmd_len = 0;
  logic [15:0] wr_data = 0, rd_data, start_addr, dev_in, dev_out = 0;
  logic        wr_valid = 0, wr_ready, rd_valid, rd_ready = 0;
  logic        busy, done, err, rqst, rd_wr, dev_ack, dma_ack = 0, end_flag = 0;
  logic [4:0]  num_words;

  dma_dev_port dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd_wr(cmd_rd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err), .rqst(rqst), .rd_wr(rd_wr),
    .start_addr(start_addr), .num_words(num_words), .dev_ack(dev_ack),
    .dev_in(dev_in), .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int rqst_cnt = 0, beats = 0;
  logic [15:0] rq_addr;
  logic [4:0]  rq_len;
  logic        rq_rw;
  logic        ctl_en = 0, rd_en = 0;
  logic [15:0] src_q[$], ctl_q[$], exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: outputs are state-only, so handshakes decided here land on the next rising edge.
  task automatic tick();
    @(negedge clk);
    cmd_valid = 0;
    end_flag  = 0;
    if (rqst) begin
      rqst_cnt++;
      rq_addr = start_addr; rq_len = num_words; rq_rw = rd_wr;
    end
    wr_valid = (src_q.size() > 0);
    wr_data  = wr_valid ? src_q[0] : 16'h0;
    if (wr_valid && wr_ready) exp_q.push_back(src_q.pop_front());
    dma_ack = 0;
    if (ctl_en && dev_ack) begin
      if (rd_wr) begin
        if (ctl_q.size() > 0) begin
          dma_ack = 1;
          dev_out = ctl_q.pop_front();
          exp_q.push_back(dev_out);
        end
      end else begin
        dma_ack = 1;
        check("dev_in", {16'h0, dev_in}, exp_q.size() > 0 ? {16'h0, exp_q.pop_front()} : 'x);
        beats++;
      end
    end
    rd_ready = rd_en;
    if (rd_en && rd_valid) begin
      check("rd_data", {16'h0, rd_data}, exp_q.size() > 0 ? {16'h0, exp_q.pop_front()} : 'x);
      beats++;
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [15:0] addr, input logic [4:0] len);
    cmd_rd_wr = rw; cmd_addr = addr; cmd_len = len; cmd_valid = 1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) break;
    end
    check(tag, done, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {busy, done, err, rqst, rd_wr, dev_ack, wr_ready, rd_valid}, 0);
    check({tag, "_addr"}, {start_addr, num_words}, 0);
    check({tag, "_data"}, {dev_in, rd_data}, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    #2 reset = 0;
    #1 check_reset_outs("init");
    repeat (2) @(negedge clk);
    reset = 1;

    // write 4 words
    rqst_cnt = 0; beats = 0; ctl_en = 1; rd_en = 0;
    src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tick(); send_cmd(0, 16'h0200, 5'd4);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (beats == 4) break;
    end
    check("wr_beats", beats, 4);
    check("wr_ready_at_len", wr_ready, 0);
    end_flag = 1;
    tick(); check("wr_done_pulse", done, 1);
    tick(); check("wr_done_end", {done, cmd_ready}, 2'b01);
    check("wr_rqst_cycles", rqst_cnt, 2);
    check("wr_req_fields", {rq_addr, rq_len, rq_rw}, {16'h0200, 5'd4, 1'b0});

    // read 8 words with the core stalled
    rqst_cnt = 0; beats = 0; ctl_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) ctl_q.push_back(16'hA000 + 16'(i * 17));
    tick(); send_cmd(1, 16'h0400, 5'd8);
    repeat (20) tick();
    check("rd_beats_taken", ctl_q.size(), 1);
    check("rd_stall_dev_ack", dev_ack, 0);
    check("rd_stall_count", dut.count, 7);
    rd_en = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ctl_q.size() == 0) break;
    end
    end_flag = 1;
    wait_done("rd_done");
    check("rd_all_delivered", {exp_q.size(), beats}, {32'd0, 32'd8});
    check("rd_req_fields", {rqst_cnt[3:0], rq_addr, rq_len, rq_rw}, {4'd2, 16'h0400, 5'd8, 1'b1});

    // simultaneous push/pop at occupancy 3 across pointer wrap
    beats = 0; rd_en = 0; ctl_q.delete(); exp_q.delete();
    for (int i = 0; i < 12; i++) ctl_q.push_back(16'hC000 + 16'(i));
    tick(); send_cmd(1, 16'h0010, 5'd12);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctl_q.size() == 9) break;
    end
    ctl_en = 0;
    tick(); check("wrap_occ_start", dut.count, 3);
    ctl_en = 1; rd_en = 1;
    repeat (5) tick();
    check("wrap_occ_steady", dut.count, 3);
    check("wrap_model_occ", exp_q.size(), 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctl_q.size() == 0) break;
    end
    end_flag = 1;
    wait_done("wrap_done");
    check("wrap_beats", beats, 12);
    rd_en = 0;

    // zero-length command
    rqst_cnt = 0;
    tick(); send_cmd(0, 16'h0300, 5'd0);
    tick(); check("zl_done_err", {done, err}, 2'b11);
    tick(); check("zl_after", {done, err, cmd_ready}, 3'b011);
    check("zl_no_rqst", rqst_cnt, 0);

    // dma_ack while dev_ack is low
    ctl_en = 0; beats = 0; exp_q.delete();
    tick(); send_cmd(0, 16'h0500, 5'd2);
    tick(); check("err_clr_on_accept", err, 0);
    tick(); tick();
    dma_ack = 1;
    tick(); check("stray_ack_err", {err, dev_ack}, 2'b10);
    check("stray_ack_count", dut.count, 0);
    src_q = '{16'hAAAA, 16'hBBBB}; ctl_en = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (beats == 2) break;
    end
    end_flag = 1;
    wait_done("stray_done");
    check("stray_beats", beats, 2);

`ifdef DMA_DEV_TIMEOUT_EN
    ctl_en = 0;
    tick(); send_cmd(0, 16'h0600, 5'd1);
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (done) break;
    end
    check("tout_done_err", {done, err}, 2'b11);
    tick();
`endif

    // reset mid-read with 5 words buffered
    ctl_en = 1; rd_en = 0; ctl_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) ctl_q.push_back(16'h5000 + 16'(i));
    tick(); send_cmd(1, 16'h0700, 5'd8);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ctl_q.size() == 3) break;
    end
    ctl_en = 0;
    tick(); check("pre_rst_count", dut.count, 5);
    #2 reset = 0;
    #1 check_reset_outs("midrst");
    check("midrst_count", dut.count, 0);
    @(negedge clk); reset = 1;
    tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
